// File: rtl/idivu_pkg.sv
// Shared helpers for the iterative unsigned divider.
package idivu_pkg;

  // Bits needed to count WIDTH iterations, never less than one.
  function automatic int cnt_width(input int width);
    int cw;
    cw = $clog2(width);
    if (cw < 1) begin
      cw = 1;
    end
    return cw;
  endfunction

endpackage

// File: rtl/idivu_step.sv
// One restoring shift-subtract step: shifts the accumulator left and, if the
// divisor fits into the top part, subtracts it and sets the new quotient bit.
module idivu_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   dm,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH:0]   top_s;
  logic [WIDTH:0]   diff_s;

  always_comb begin
    shifted_s = {acc, 1'b0};
    top_s     = shifted_s[2*WIDTH:WIDTH];
    diff_s    = top_s - {1'b0, dm};
    if (top_s >= {1'b0, dm}) begin
      acc_next = {diff_s[WIDTH-1:0], shifted_s[WIDTH-1:1], 1'b1};
    end else begin
      acc_next = shifted_s[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/idivu.sv
// Iterative unsigned divider, 2*WIDTH / WIDTH bits, one quotient bit per clock.
// Overflow (including divide-by-zero) is resolved at accept without iterating.
module idivu
  import idivu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  output logic                 busy,
  input  logic                 go,
  input  logic [2*WIDTH-1:0]   n,
  input  logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     r,
  output logic                 ovf
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] dm_q, dm_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [DW-1:0]    acc_step_s;
  logic             ovf_now_s;

  idivu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .dm       (dm_q),
    .acc_next (acc_step_s)
  );

  assign ovf_now_s = (n[DW-1:WIDTH] >= d);

  always_comb begin
    acc_d   = acc_q;
    dm_d    = dm_q;
    count_d = count_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    if (busy_q) begin
      acc_d = acc_step_s;
      if (count_q != '0) begin
        count_d = count_q - CW'(1);
      end else begin
        busy_d = 1'b0;
      end
    end else if (go) begin
      if (ovf_now_s) begin
        // Saturated quotient, remainder reports the dividend's high half.
        ovf_d = 1'b1;
        acc_d = {n[DW-1:WIDTH], {WIDTH{1'b1}}};
      end else begin
        ovf_d   = 1'b0;
        acc_d   = n;
        dm_d    = d;
        count_d = CW'(WIDTH - 1);
        busy_d  = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc_q   <= '0;
      dm_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      dm_q    <= dm_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign q    = acc_q[WIDTH-1:0];
  assign r    = acc_q[DW-1:WIDTH];

endmodule

// File: tb/tb_idivu.sv
// Self-checking bench for idivu at WIDTH=8 and WIDTH=32 against an arithmetic model.
module tb_idivu;

  logic        clk = 1'b0;
  logic        arst8, arst32;
  logic        go8, go32;
  logic [15:0] n8;
  logic [7:0]  d8;
  logic [63:0] n32;
  logic [31:0] d32;
  logic        busy8, busy32, ovf8, ovf32;
  logic [7:0]  q8, r8;
  logic [31:0] q32, r32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idivu #(.WIDTH(8)) dut8 (
    .clk(clk), .arst(arst8), .busy(busy8), .go(go8),
    .n(n8), .d(d8), .q(q8), .r(r8), .ovf(ovf8)
  );

  idivu #(.WIDTH(32)) dut32 (
    .clk(clk), .arst(arst32), .busy(busy32), .go(go32),
    .n(n32), .d(d32), .q(q32), .r(r32), .ovf(ovf32)
  );

  // Pulse go for one cycle, then count busy cycles (bounded) until results are valid.
  task automatic run8(input logic [15:0] nn, input logic [7:0] dd, output int cyc);
    @(negedge clk);
    n8 = nn; d8 = dd; go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run32(input logic [63:0] nn, input logic [31:0] dd, output int cyc);
    @(negedge clk);
    n32 = nn; d32 = dd; go32 = 1'b1;
    @(negedge clk);
    go32 = 1'b0;
    cyc = 0;
    while (busy32 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    arst8 = 1'b1; arst32 = 1'b1;
    go8 = 1'b0; go32 = 1'b0; n8 = '0; d8 = '0; n32 = '0; d32 = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy8, ovf8, q8, r8} !== 18'h0) begin
      bad++;
      $display("FAIL reset8: got busy=%b ovf=%b q=%h r=%h, want all 0", busy8, ovf8, q8, r8);
    end
    total++;
    if ({busy32, ovf32, q32, r32} !== 66'h0) begin
      bad++;
      $display("FAIL reset32: got busy=%b ovf=%b q=%h r=%h, want all 0", busy32, ovf32, q32, r32);
    end
    arst8 = 1'b0; arst32 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    run8(16'd1000, 8'd7, cyc);
    total++;
    if ({cyc, ovf8, q8, r8} !== {32'd8, 1'b0, 8'd142, 8'd6}) begin
      bad++;
      $display("FAIL div_1000_7: got cyc=%0d ovf=%b q=%0d r=%0d, want 8 0 142 6", cyc, ovf8, q8, r8);
    end
    run8(16'hFEFF, 8'hFF, cyc);
    total++;
    if ({cyc, ovf8, q8, r8} !== {32'd8, 1'b0, 8'hFF, 8'hFE}) begin
      bad++;
      $display("FAIL div_max: got cyc=%0d ovf=%b q=%h r=%h, want 8 0 ff fe", cyc, ovf8, q8, r8);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    run8(16'h1234, 8'h12, cyc);
    total++;
    if ({cyc, busy8, ovf8, q8, r8} !== {32'd0, 1'b0, 1'b1, 8'hFF, 8'h12}) begin
      bad++;
      $display("FAIL ovf_1234_12: got cyc=%0d busy=%b ovf=%b q=%h r=%h, want 0 0 1 ff 12",
               cyc, busy8, ovf8, q8, r8);
    end
    run8(16'h0005, 8'h00, cyc);
    total++;
    if ({cyc, ovf8, q8, r8} !== {32'd0, 1'b1, 8'hFF, 8'h00}) begin
      bad++;
      $display("FAIL div_by_zero: got cyc=%0d ovf=%b q=%h r=%h, want 0 1 ff 00", cyc, ovf8, q8, r8);
    end
    // A following normal division must clear ovf.
    run8(16'd50, 8'd5, cyc);
    total++;
    if ({ovf8, q8, r8} !== {1'b0, 8'd10, 8'd0}) begin
      bad++;
      $display("FAIL ovf_clear: got ovf=%b q=%0d r=%0d, want 0 10 0", ovf8, q8, r8);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    n8 = 16'd100; d8 = 8'd9; go8 = 1'b1;
    @(negedge clk);
    n8 = 16'd200; d8 = 8'd3;
    cyc = 0;
    while (busy8 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    total++;
    if ({cyc, busy8, ovf8, q8, r8} !== {32'd8, 1'b0, 1'b0, 8'd11, 8'd1}) begin
      bad++;
      $display("FAIL go_held_first: got cyc=%0d busy=%b ovf=%b q=%0d r=%0d, want 8 0 0 11 1",
               cyc, busy8, ovf8, q8, r8);
    end
    @(negedge clk);
    go8 = 1'b0;
    total++;
    if (busy8 !== 1'b1) begin
      bad++;
      $display("FAIL go_held_accept: got busy=%b, want 1", busy8);
    end
    cyc = 0;
    while (busy8 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    total++;
    if ({cyc, ovf8, q8, r8} !== {32'd8, 1'b0, 8'd66, 8'd2}) begin
      bad++;
      $display("FAIL go_held_second: got cyc=%0d ovf=%b q=%0d r=%0d, want 8 0 66 2", cyc, ovf8, q8, r8);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    n8 = 16'd1000; d8 = 8'd7; go8 = 1'b1;
    @(negedge clk);
    go8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 arst8 = 1'b1;
    #1;
    total++;
    if ({busy8, ovf8, q8, r8} !== 18'h0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b ovf=%b q=%h r=%h, want all 0", busy8, ovf8, q8, r8);
    end
    @(negedge clk);
    arst8 = 1'b0;
    run8(16'd255, 8'd16, cyc);
    total++;
    if ({cyc, ovf8, q8, r8} !== {32'd8, 1'b0, 8'd15, 8'd15}) begin
      bad++;
      $display("FAIL after_reset: got cyc=%0d ovf=%b q=%0d r=%0d, want 8 0 15 15", cyc, ovf8, q8, r8);
    end
  endtask

  task automatic test_random8();
    int cyc, ecyc;
    logic [15:0] nn;
    logic [7:0]  dd, eq, er;
    logic        eo;
    for (int i = 0; i < 1000; i++) begin
      nn = 16'($urandom);
      dd = 8'($urandom);
      if (i % 16 == 0) dd = 8'h00;
      if ((i % 3 != 0) && (dd != 8'h00)) nn[15:8] = nn[15:8] % dd;
      eo = (nn[15:8] >= dd);
      if (eo) begin
        eq = 8'hFF; er = nn[15:8]; ecyc = 0;
      end else begin
        eq = 8'(nn / dd); er = 8'(nn % dd); ecyc = 8;
      end
      run8(nn, dd, cyc);
      total++;
      if ({cyc, ovf8, q8, r8} !== {ecyc, eo, eq, er}) begin
        bad++;
        $display("FAIL rand8 n=%h d=%h: got cyc=%0d ovf=%b q=%h r=%h, want %0d %b %h %h",
                 nn, dd, cyc, ovf8, q8, r8, ecyc, eo, eq, er);
      end
      if (!eo) begin
        total++;
        if (!((32'(q8) * 32'(dd) + 32'(r8) == 32'(nn)) && (r8 < dd))) begin
          bad++;
          $display("FAIL rand8_identity n=%h d=%h: got q=%h r=%h, want q*d+r==n and r<d", nn, dd, q8, r8);
        end
      end
    end
  endtask

  task automatic test_random32();
    int cyc, ecyc;
    logic [63:0]  nn;
    logic [31:0]  dd, eq, er;
    logic         eo;
    logic [127:0] prod;
    for (int i = 0; i < 1000; i++) begin
      nn = {$urandom, $urandom};
      dd = $urandom;
      if (i % 20 == 0) dd = 32'h0;
      if (i % 7 == 1) dd = 32'hFFFF_FFFF;
      if ((i % 3 != 0) && (dd != 32'h0)) nn[63:32] = nn[63:32] % dd;
      eo = (nn[63:32] >= dd);
      if (eo) begin
        eq = 32'hFFFF_FFFF; er = nn[63:32]; ecyc = 0;
      end else begin
        eq = 32'(nn / 64'(dd)); er = 32'(nn % 64'(dd)); ecyc = 32;
      end
      run32(nn, dd, cyc);
      total++;
      if ({cyc, ovf32, q32, r32} !== {ecyc, eo, eq, er}) begin
        bad++;
        $display("FAIL rand32 n=%h d=%h: got cyc=%0d ovf=%b q=%h r=%h, want %0d %b %h %h",
                 nn, dd, cyc, ovf32, q32, r32, ecyc, eo, eq, er);
      end
      if (!eo) begin
        prod = 128'(q32) * 128'(dd) + 128'(r32);
        total++;
        if (!((prod == 128'(nn)) && (r32 < dd))) begin
          bad++;
          $display("FAIL rand32_identity n=%h d=%h: got q=%h r=%h, want q*d+r==n and r<d", nn, dd, q32, r32);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_random32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
